// File: rtl/regfile_if.sv
// Register file port bundle: one write port and two combinational read ports.
// The datapath (master) drives addresses and write data; the register file
// (slave) returns read data.
interface regfile_if #(
  parameter int N = 32
);
  logic         wr_ena;
  logic [4:0]   wr_addr;
  logic [N-1:0] wr_data;
  logic [4:0]   rd_addr0;
  logic [N-1:0] rd_data0;
  logic [4:0]   rd_addr1;
  logic [N-1:0] rd_data1;

  modport master (
    output wr_ena, wr_addr, wr_data, rd_addr0, rd_addr1,
    input  rd_data0, rd_data1
  );

  modport slave (
    input  wr_ena, wr_addr, wr_data, rd_addr0, rd_addr1,
    output rd_data0, rd_data1
  );
endinterface

// File: rtl/register_file.sv
// 32 x 32-bit architectural register file for the single-cycle RISC-V
// datapath. x0 reads as zero and has no storage; x1..x31 are flops cleared
// asynchronously by rst. Two combinational read ports with optional
// same-cycle write-to-read forwarding.
module register_file #(
  parameter int N      = 32,
  parameter int L      = 32,
  parameter bit BYPASS = 1'b1
) (
  input  logic     clk,
  input  logic     rst,
  regfile_if.slave bus
);

  logic [N-1:0] regs [1:L-1];
  logic [L-1:1] wr_sel;
  logic         fwd0;
  logic         fwd1;
  logic [N-1:0] stored0;
  logic [N-1:0] stored1;

  // One-hot write decode; address 0 never selects anything.
  always_comb begin
    wr_sel = '0;
    for (int i = 1; i < L; i++) begin
      if (bus.wr_ena && (bus.wr_addr == 5'(i))) wr_sel[i] = 1'b1;
    end
  end

  // Storage: async clear dominates, otherwise per-register write enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 1; i < L; i++) regs[i] <= '0;
    end else begin
      for (int i = 1; i < L; i++) begin
        if (wr_sel[i]) regs[i] <= bus.wr_data;
      end
    end
  end

  // Stored-value read muxes; an address of 0 falls through to zero.
  always_comb begin
    stored0 = '0;
    stored1 = '0;
    for (int i = 1; i < L; i++) begin
      if (bus.rd_addr0 == 5'(i)) stored0 = regs[i];
      if (bus.rd_addr1 == 5'(i)) stored1 = regs[i];
    end
  end

  // Forwarding qualifiers; never forward to x0 or while in reset.
  always_comb begin
    fwd0 = BYPASS && !rst && bus.wr_ena && (bus.wr_addr != 5'd0) &&
           (bus.wr_addr == bus.rd_addr0);
    fwd1 = BYPASS && !rst && bus.wr_ena && (bus.wr_addr != 5'd0) &&
           (bus.wr_addr == bus.rd_addr1);
  end

  // Output select: reset forces zero, then forwarded data, then storage.
  always_comb begin
    bus.rd_data0 = stored0;
    bus.rd_data1 = stored1;
    if (rst) begin
      bus.rd_data0 = '0;
      bus.rd_data1 = '0;
    end else begin
      if (fwd0) bus.rd_data0 = bus.wr_data;
      if (fwd1) bus.rd_data1 = bus.wr_data;
    end
  end

endmodule

// File: tb/tb_register_file.sv
// Bench for register_file: drives a BYPASS=1 and a BYPASS=0 instance with
// identical stimulus and checks both against an array model of the
// architectural state, plus directed literal checks.
module tb_register_file;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_ena = 1'b0;
  logic [4:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic [4:0]  rd_addr0 = '0;
  logic [4:0]  rd_addr1 = '0;

  int tests = 0;
  int fails = 0;

  logic [31:0] mdl [0:31];

  regfile_if #(.N(32)) if_b ();
  regfile_if #(.N(32)) if_n ();

  assign if_b.wr_ena   = wr_ena;
  assign if_b.wr_addr  = wr_addr;
  assign if_b.wr_data  = wr_data;
  assign if_b.rd_addr0 = rd_addr0;
  assign if_b.rd_addr1 = rd_addr1;
  assign if_n.wr_ena   = wr_ena;
  assign if_n.wr_addr  = wr_addr;
  assign if_n.wr_data  = wr_data;
  assign if_n.rd_addr0 = rd_addr0;
  assign if_n.rd_addr1 = rd_addr1;

  register_file #(.N(32), .L(32), .BYPASS(1'b1)) dut_b (
    .clk(clk), .rst(rst), .bus(if_b.slave)
  );
  register_file #(.N(32), .L(32), .BYPASS(1'b0)) dut_n (
    .clk(clk), .rst(rst), .bus(if_n.slave)
  );

  always #5 clk = ~clk;

  // Architectural state model.
  initial for (int i = 0; i < 32; i++) mdl[i] = '0;
  always @(posedge rst) for (int i = 0; i < 32; i++) mdl[i] = '0;
  always @(posedge clk) begin
    if (!rst && wr_ena && wr_addr != 5'd0) mdl[wr_addr] = wr_data;
  end

  function automatic logic [31:0] exp_rd(input logic [4:0] a, input bit byp);
    if (rst) return 32'h0;
    if (a == 5'd0) return 32'h0;
    if (byp && wr_ena && wr_addr == a) return wr_data;
    return mdl[a];
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check("model_b_port0", if_b.rd_data0, exp_rd(rd_addr0, 1'b1));
    check("model_b_port1", if_b.rd_data1, exp_rd(rd_addr1, 1'b1));
    check("model_n_port0", if_n.rd_data0, exp_rd(rd_addr0, 1'b0));
    check("model_n_port1", if_n.rd_data1, exp_rd(rd_addr1, 1'b0));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string name, input logic [31:0] eb,
                           input logic [31:0] en);
    check({name, "_b0"}, if_b.rd_data0, eb);
    check({name, "_b1"}, if_b.rd_data1, eb);
    check({name, "_n0"}, if_n.rd_data0, en);
    check({name, "_n1"}, if_n.rd_data1, en);
  endtask

  initial begin
    logic [31:0] ea, eb, sum, esum;
    logic        ov, eov;

    // Reset state.
    step(); step();
    rd_addr0 = 5'd5; rd_addr1 = 5'd31;
    #1 check_all("reset", 32'h0, 32'h0);
    rst = 1'b0;

    // x0 hardwire, including during the write cycle.
    step();
    wr_ena = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFF_FFFF;
    rd_addr0 = 5'd0; rd_addr1 = 5'd0;
    #1 check_all("x0_pre", 32'h0, 32'h0);
    step();
    wr_ena = 1'b0;
    #1 check_all("x0_post", 32'h0, 32'h0);

    // Asynchronous reset clears a written register with no edge.
    wr_ena = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEAD_BEEF;
    step();
    wr_ena = 1'b0; rd_addr0 = 5'd5; rd_addr1 = 5'd5;
    #1 check_all("x5_written", 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    #1 rst = 1'b1;
    #1 check_all("async_clear", 32'h0, 32'h0);
    step();
    rst = 1'b0;
    #1 check_all("after_clear", 32'h0, 32'h0);

    // Full sweep: reg[i] = 0x01010101 * i.
    for (int i = 1; i < 32; i++) begin
      step();
      wr_ena = 1'b1; wr_addr = 5'(i); wr_data = 32'h0101_0101 * i;
    end
    step();
    wr_ena = 1'b0;
    for (int a = 0; a < 32; a++) begin
      for (int b = 0; b < 32; b++) begin
        rd_addr0 = 5'(a); rd_addr1 = 5'(b);
        #1;
        ea = 32'h0101_0101 * a;
        eb = 32'h0101_0101 * b;
        check("sweep_b0", if_b.rd_data0, ea);
        check("sweep_b1", if_b.rd_data1, eb);
        check("sweep_n0", if_n.rd_data0, ea);
        check("sweep_n1", if_n.rd_data1, eb);
        sum  = if_b.rd_data0 + if_b.rd_data1;
        ov   = (if_b.rd_data0[31] == if_b.rd_data1[31]) &&
               (sum[31] != if_b.rd_data0[31]);
        esum = ea + eb;
        eov  = (ea[31] == eb[31]) && (esum[31] != ea[31]);
        check("sweep_add", sum, esum);
        check("sweep_ovf", {31'h0, ov}, {31'h0, eov});
      end
    end

    // Same-cycle forwarding.
    step();
    wr_ena = 1'b1; wr_addr = 5'd7; wr_data = 32'h1111_1111;
    step();
    wr_data = 32'h2222_2222; rd_addr0 = 5'd7; rd_addr1 = 5'd7;
    #1 check_all("bypass_pre", 32'h2222_2222, 32'h1111_1111);
    step();
    wr_ena = 1'b0;
    #1 check_all("bypass_post", 32'h2222_2222, 32'h2222_2222);

    // Write disable holds state and never forwards.
    wr_ena = 1'b1; wr_addr = 5'd3; wr_data = 32'h0000_0003;
    step();
    wr_ena = 1'b0; wr_data = 32'hCAFE_F00D; rd_addr0 = 5'd3; rd_addr1 = 5'd3;
    for (int k = 0; k < 4; k++) begin
      #1 check_all("wr_disable", 32'h0000_0003, 32'h0000_0003);
      step();
    end

    // Random regression; the per-cycle compare process does the checking.
    for (int c = 0; c < 1000 && fails <= 10; c++) begin
      step();
      rst      = ($urandom_range(0, 99) == 0);
      wr_ena   = $urandom_range(0, 1);
      wr_addr  = 5'($urandom_range(0, 31));
      wr_data  = $urandom;
      rd_addr0 = ($urandom_range(0, 3) == 0) ? wr_addr : 5'($urandom_range(0, 31));
      rd_addr1 = ($urandom_range(0, 3) == 0) ? wr_addr : 5'($urandom_range(0, 31));
    end
    step();
    rst = 1'b0; wr_ena = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/register_file.md
Name: register_file

Overview:
- 32-entry x 32-bit architectural register file for the single-cycle RISC-V datapath.
- Sits directly upstream of the ALU: read port 0 drives ALU operand a and read port 1 drives operand b.
- Write port accepts the ALU result, or other writeback data, at the clock edge.
- Register x0 is hardwired to zero; all other entries are flip-flop storage with asynchronous clear.

Parameters:
- N, 32, data width in bits. Only 32 is supported; it is used as a constant.
- L, 32, number of registers. Fixed at 32; the address width is 5.
- BYPASS, 1, when 1, a same-cycle write to the address being read is forwarded to the read port.

Ports:
- clk  input  1  system clock; all writes occur on the rising edge.
- rst  input  1  reset, asynchronous, active-high; clears every register.
- wr_ena  input  1  write enable, sampled on the rising clk edge.
- wr_addr  input  5  destination register index.
- wr_data  input  N  data to write.
- rd_addr0  input  5  read port 0 index (rs1).
- rd_data0  output  N  read port 0 data, combinational (feeds ALU a).
- rd_addr1  input  5  read port 1 index (rs2).
- rd_data1  output  N  read port 1 data, combinational (feeds ALU b).

Behaviour:
- Reset: one clock; reset is asynchronous and active-high.
  - rst high immediately (no clock needed) clears registers 1..31 to 0.
  - Both rd_data outputs read 0 while rst is high, regardless of address.
  - rst asserted mid-write: the clear wins. No write occurs on any edge where rst is high.
- Write:
  - On posedge clk with rst low and wr_ena high, reg[wr_addr] <= wr_data.
  - The new value is visible on the read ports after the edge.
  - wr_ena low: no state change.
  - wr_addr == 0: the write is discarded, and x0 stays 0 permanently.
- Read:
  - rd_dataK = 0 if rd_addrK == 0; otherwise rd_dataK = reg[rd_addrK].
  - Purely combinational, zero-cycle latency; settles within the same cycle.
  - Both ports may read the same address simultaneously; both return identical data.
- Bypass (BYPASS=1):
  - If wr_ena is high, wr_addr != 0 and wr_addr == rd_addrK, then rd_dataK = wr_data combinationally in the same cycle, before the edge.
  - Applies independently to each port; both ports may bypass simultaneously.
  - Bypass is suppressed for x0 and while rst is high.
- No bypass (BYPASS=0):
  - Reads return the pre-edge stored value.
  - The written value appears on the cycle after the edge.
- Read-after-write timing: the value written at edge n is returned by a non-bypassed read of that address for all cycles after edge n until the next write or reset.
- No X propagation:
  - With all inputs known, outputs are never X.
  - Uninitialised state does not exist, because reset is required before use.
- Storage: an array of 31 N-bit registers (x1..x31) with a per-register write-enable decode from wr_addr; x0 has no storage.

Test Plan:
- Reset clear:
  - Write 0xDEADBEEF to x5, then assert rst mid-cycle (asynchronous, between edges).
  - Required: rd_data0 with rd_addr0=5 reads 0x00000000 immediately, with no clock edge needed. It still reads 0 after rst deasserts.
- x0 hardwire:
  - wr_ena=1, wr_addr=0, wr_data=0xFFFFFFFF, one edge; then read x0 on both ports.
  - Required: both read 0x00000000. With BYPASS=1, both also read 0 during the write cycle.
- Full sweep:
  - Write reg[i] = 0x01010101*i for i=1..31 over 31 cycles.
  - Then read every (rd_addr0, rd_addr1) pair.
  - Required: each port returns its index value, and x0 returns 0.
  - Also feed the outputs into alu with control ADD and check result = rd_data0 + rd_data1, with overflow matching alu_behavioural.
- Same-cycle bypass:
  - x7 = 0x11111111; then wr_ena=1, wr_addr=7, wr_data=0x22222222, with rd_addr0=rd_addr1=7 before the edge.
  - Required: BYPASS=1 gives 0x22222222 on both ports pre-edge. BYPASS=0 gives 0x11111111 pre-edge and 0x22222222 after the edge.
- Write disable:
  - wr_ena=0, wr_addr=3, wr_data=0xCAFEF00D over 4 edges, with x3 previously 0x00000003.
  - Required: x3 stays 0x00000003, and bypass does not trigger.
- Random regression:
  - 1000 cycles of random wr_ena/addresses/data against a behavioural array model; count mismatches per port and quit after more than 10 errors.
  - Required: 0 errors.
